serial_add_ctrl: RTL
====================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter CHUNKS, default 4, giving the number of 3-bit slices per operand; operand width W = 3*CHUNKS.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to begin an addition.
REQ-005 The block SHALL have port a, input, W, first operand.
REQ-006 The block SHALL have port b, input, W, second operand.
REQ-007 The block SHALL have port cin, input, 1, carry-in to the least significant slice.
REQ-008 The block SHALL have port sum, output, W, registered result.
REQ-009 The block SHALL have port cout, output, 1, registered carry-out of the most significant slice.
REQ-010 The block SHALL have port busy, output, 1, high while an addition is in progress.
REQ-011 The block SHALL have port done, output, 1, single-cycle pulse marking a valid result.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE with start=1, the block SHALL latch a, b into operand registers, load the carry register with cin, clear sum and cout to 0, set slice index to 0, and enter RUN.
REQ-014 Each RUN cycle SHALL compute {c,s} = a_reg[3i+2:3i] + b_reg[3i+2:3i] + carry, with i the slice index, 4-bit unsigned result.
REQ-015 Each RUN cycle SHALL write s into sum[3i+2:3i], write c into the carry register, and increment i.
REQ-016 When i = CHUNKS-1 in RUN, the block SHALL also write c to cout and enter DONE at the next edge.
REQ-017 RUN SHALL last exactly CHUNKS cycles; done SHALL be high for exactly one cycle, CHUNKS+1 cycles after the edge accepting start (5 cycles for CHUNKS=4).
REQ-018 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-019 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-020 start SHALL be ignored in RUN and DONE; no queuing of requests.
REQ-021 Changes on a, b, cin after acceptance SHALL NOT affect the in-flight result.
REQ-022 sum and cout SHALL hold their final values after done until the next accepted start.
REQ-023 Slice index width SHALL be ceil(log2(CHUNKS)), minimum 1, and SHALL never exceed CHUNKS-1.
REQ-024 The result SHALL equal (a + b + cin) mod 2^W in sum, with bit W in cout.

Reset
REQ-025 When reset=1 at a clock edge, the block SHALL enter IDLE and clear sum, cout, busy, done, carry, index and operand registers to 0.
REQ-026 Reset SHALL take priority over start and over any in-flight operation; an aborted addition SHALL produce no done pulse.
REQ-027 Reset SHALL have no asynchronous effect; outputs change only on a clock edge.

Verification
REQ-028 Reset held 2 cycles -> sum=0, cout=0, busy=0, done=0.
REQ-029 a=12'hFFF, b=12'h001, cin=0, start pulse -> done on 5th cycle after acceptance, sum=12'h000, cout=1.
REQ-030 a=12'h123, b=12'h456, cin=1 -> sum=12'h57A, cout=0; a, b toggled to 12'h000 during RUN must not change the result.
REQ-031 start held high continuously from IDLE for 12 cycles -> acceptances 6 cycles apart, done pulses only at cycles 5 and 11, busy low only in the IDLE accept cycles.
REQ-032 reset asserted on 2nd RUN cycle of a=12'h800, b=12'h800 -> next cycle IDLE, all outputs 0, no done pulse.
REQ-033 Random regression, 1000 operand/cin triples -> {cout,sum} equals a+b+cin at every done.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial-by-slice adder controller.
// Adds two W-bit operands plus carry-in three bits per cycle over CHUNKS
// cycles, then pulses done for one cycle and holds the result until the
// next accepted start.
module serial_add_ctrl #(
    parameter  int unsigned CHUNKS = 4,
    localparam int unsigned W      = 3 * CHUNKS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy,
    output logic         done
);

    localparam int unsigned IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic [3:0]    slice;

    // State and datapath registers; reset clears everything and aborts any run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state logic and one 3-bit slice addition per RUN cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        slice   = {1'b0, a_q[3*idx_q +: 3]} + {1'b0, b_q[3*idx_q +: 3]}
                + {3'b000, carry_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[3*idx_q +: 3] = slice[2:0];
                carry_d             = slice[3];
                if (idx_q == LAST) begin
                    // Index returns to 0 rather than wrapping, so it never
                    // exceeds CHUNKS-1 when CHUNKS is not a power of two.
                    cout_d  = slice[3];
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule
